// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM-stage initiator and dmem_responder.
// The pipeline drives the master side; the responder uses the slave side.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-enable stores and a fixed-latency response pulse.
// Define DMEM_RESP_ERRCHK_EN to flag misaligned and out-of-range accesses.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // With zero latency the commit edge is the accept edge, so take the live request.
    logic              from_idle;
    logic              src_we;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;
    logic [3:0]        src_be;
    logic [IDX_W-1:0]  widx;
    logic              fault;
    logic              commit;

    assign from_idle = (state_q == S_IDLE);
    assign src_we    = from_idle ? bus.req_we    : we_q;
    assign src_addr  = from_idle ? bus.req_addr  : addr_q;
    assign src_wdata = from_idle ? bus.req_wdata : wdata_q;
    assign src_be    = from_idle ? bus.req_be    : be_q;
    assign widx      = src_addr[IDX_W+1:2];
    assign commit    = (state_d == S_RESP) && !rst;

`ifdef DMEM_RESP_ERRCHK_EN
    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
    endfunction

    assign fault = addr_fault(src_addr);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[ADDR_W-1:IDX_W+2], src_addr[1:0]};
    assign fault            = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    always_ff @(posedge clk) begin
        if (commit && src_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (src_be[i]) begin
                    mem[widx][8*i +: 8] <= src_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers hold between pulses; only a commit or reset changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= fault;
            rdata_q <= (src_we || fault) ? '0 : mem[widx];
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
// Fault expectations follow whether DMEM_RESP_ERRCHK_EN is defined for the build.
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] b2b_data [3];

    dmem_responder_if #(.ADDR_W(32)) dif ();
    dmem_responder_if #(.ADDR_W(32)) dif0 ();

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (dif0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
        int lat;
        logic got;
        @(negedge clk);
        check({tag, "_ready"}, 32'(dif.req_ready), 32'd1);
        dif.req_valid = 1'b1;
        dif.req_we    = we;
        dif.req_addr  = addr;
        dif.req_wdata = wdata;
        dif.req_be    = be;
        @(posedge clk);
        @(negedge clk);
        dif.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 20) begin
            if (dif.resp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, dif.resp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(dif.resp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(dif.resp_valid), 32'd0);
        check({tag, "_rdata_hold"}, dif.resp_rdata, exp_rdata);
    endtask

    task automatic lat0_burst(input logic we);
        @(negedge clk);
        dif0.req_valid = 1'b1;
        dif0.req_we    = we;
        dif0.req_be    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            dif0.req_addr  = 32'h40 + 32'(4 * i);
            dif0.req_wdata = b2b_data[i];
            check("b2b_ready_idle", 32'(dif0.req_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("b2b_resp_valid", 32'(dif0.resp_valid), 32'd1);
            check("b2b_ready_resp", 32'(dif0.req_ready), 32'd0);
            check("b2b_rdata", dif0.resp_rdata, we ? 32'h0 : b2b_data[i]);
            @(posedge clk);
            @(negedge clk);
            check("b2b_pulse_end", 32'(dif0.resp_valid), 32'd0);
        end
        dif0.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        b2b_data[0] = 32'hA0A0_0001;
        b2b_data[1] = 32'hB0B0_0002;
        b2b_data[2] = 32'hC0C0_0003;
        dif.req_valid  = 1'b0;
        dif.req_we     = 1'b0;
        dif.req_addr   = 32'h0;
        dif.req_wdata  = 32'h0;
        dif.req_be     = 4'h0;
        dif0.req_valid = 1'b0;
        dif0.req_we    = 1'b0;
        dif0.req_addr  = 32'h0;
        dif0.req_wdata = 32'h0;
        dif0.req_be    = 4'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(dif.req_ready), 32'd1);
        check("reset_valid", 32'(dif.resp_valid), 32'd0);
        check("reset_rdata", dif.resp_rdata, 32'h0);
        check("reset_err", 32'(dif.resp_err), 32'd0);
        check("reset_ready0", 32'(dif0.req_ready), 32'd1);
        rst = 1'b0;

        // Reset during WAIT must abort the store and clear the response registers.
        xact(1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "pre_store");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, "pre_load");
        @(negedge clk);
        dif.req_valid = 1'b1;
        dif.req_we    = 1'b1;
        dif.req_addr  = 32'h10;
        dif.req_wdata = 32'hDEAD_BEEF;
        dif.req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        dif.req_valid = 1'b0;
        check("rstwait_busy", 32'(dif.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstwait_ready", 32'(dif.req_ready), 32'd1);
        check("rstwait_valid", 32'(dif.resp_valid), 32'd0);
        check("rstwait_rdata", dif.resp_rdata, 32'h0);
        check("rstwait_err", 32'(dif.resp_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstwait_valid2", 32'(dif.resp_valid), 32'd0);
        rst = 1'b0;
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, "rstwait_load");

        xact(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "st20");
        xact(1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "ld20");

        xact(1'b1, 32'h24, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, "st24_full");
        xact(1'b1, 32'h24, 32'h1122_3344, 4'h5, 32'h0, 1'b0, "st24_be5");
        xact(1'b0, 32'h24, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, "ld24_merge");
        xact(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "st24_be0");
        xact(1'b0, 32'h24, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, "ld24_after_be0");

        lat0_burst(1'b1);
        lat0_burst(1'b0);

`ifdef DMEM_RESP_ERRCHK_EN
        xact(1'b1, 32'h0, 32'h0000_1111, 4'hF, 32'h0, 1'b0, "flt_seed");
        xact(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, "flt_misalign");
        xact(1'b1, 32'h400, 32'h0000_00FF, 4'hF, 32'h0, 1'b1, "flt_range");
        xact(1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_1111, 1'b0, "flt_noalias");
`else
        xact(1'b1, 32'h0, 32'h0000_1111, 4'hF, 32'h0, 1'b0, "wrap_seed");
        xact(1'b1, 32'h400, 32'h0000_00FF, 4'hF, 32'h0, 1'b0, "wrap_store");
        xact(1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, "wrap_load");
        xact(1'b0, 32'h22, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "wrap_unaligned");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
